// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
// Shared definitions for the fetch sequencer: FSM state encodings,
// MIPS-style opcode/funct constants and PC-source select codes.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PCUPD  = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } seqState_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  localparam logic [1:0] PCSEL_BR  = 2'b00;
  localparam logic [1:0] PCSEL_J   = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;

endpackage

// File: rtl/fetch_seq_decode.sv
// fetch_seq_decode
// Purely combinational opcode/funct classifier used by the sequencer FSM.
// Ports:
//   opcode_i     : instruction opcode field
//   funct_i      : instruction funct field (meaningful for R-type only)
//   is_branch_o  : BEQ or BNE
//   is_jump_o    : J or JAL (PC update without a conditional execute)
//   is_jr_o      : R-type JR
//   is_break_o   : R-type BREAK
//   needs_exec_o : instruction needs the datapath (everything except plain J)
module fetch_seq_decode
  import fetch_seq_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       is_branch_o,
  output logic       is_jump_o,
  output logic       is_jr_o,
  output logic       is_break_o,
  output logic       needs_exec_o
);

  // Classification is a set of independent compares; JAL still needs the
  // datapath for its link writeback, so only plain J skips execute.
  always_comb begin
    is_branch_o  = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
    is_jump_o    = (opcode_i == OP_J) || (opcode_i == OP_JAL);
    is_jr_o      = (opcode_i == OP_RTYPE) && (funct_i == FN_JR);
    is_break_o   = (opcode_i == OP_RTYPE) && (funct_i == FN_BREAK);
    needs_exec_o = (opcode_i != OP_J);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Multi-cycle control FSM sequencing PC / instruction memory / IR through
// FETCH, DECODE, EXEC and PCUPD, with a start/done handshake to the datapath.
// All outputs are registered decodes of the state being entered, so they
// line up with the 'state' debug output.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   opcode, funct     : IR fields, sampled in DECODE
//   alu_z, ex_done    : datapath zero flag and execute-complete
//   ex_start          : one-cycle datapath start pulse
//   pc_sel/pc_ld/pc_inc : PC source select, load, increment
//   im_cs/im_rd/im_wr : instruction memory controls (im_wr tied low)
//   ir_ld             : IR load
//   halted, err       : HALT state flag, sticky execute-timeout flag
//   state             : current state encoding
//   retired           : completed-instruction count (FETCH_SEQ_RETIRE_CNT_EN only)
// Build option: define FETCH_SEQ_RETIRE_CNT_EN to add the 'retired' counter.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int HALT_ON_BREAK = 1,
  parameter int EXEC_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_z,
  input  logic        ex_done,
  output logic        ex_start,
  output logic [1:0]  pc_sel,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        im_cs,
  output logic        im_rd,
  output logic        im_wr,
  output logic        ir_ld,
  output logic        halted,
  output logic        err,
  output logic [2:0]  state
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam int WaitW = $clog2(EXEC_TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(EXEC_TIMEOUT - 1);

  seqState_t        state_q, state_d;
  logic [5:0]       opHeld_q, fnHeld_q;
  logic [5:0]       decOp, decFn;
  logic [WaitW-1:0] waitCnt_q;
  logic             exStart_d;
  logic [1:0]       pcSel_d;
  logic             isBranch, isJump, isJr, isBreak, needsExec;
  logic             brTaken;

  // In DECODE the live IR is classified; afterwards the held copy is used so
  // IR changes during EXEC cannot redirect the instruction in flight.
  assign decOp = (state_q == ST_DECODE) ? opcode : opHeld_q;
  assign decFn = (state_q == ST_DECODE) ? funct  : fnHeld_q;

  fetch_seq_decode uDecode (
    .opcode_i     (decOp),
    .funct_i      (decFn),
    .is_branch_o  (isBranch),
    .is_jump_o    (isJump),
    .is_jr_o      (isJr),
    .is_break_o   (isBreak),
    .needs_exec_o (needsExec)
  );

  assign brTaken = isBranch && (((decOp == OP_BEQ) && alu_z) ||
                                ((decOp == OP_BNE) && !alu_z));

  // Next-state logic. A zero wait count marks the ex_start cycle, in which
  // ex_done is deliberately ignored.
  always_comb begin
    state_d   = state_q;
    exStart_d = 1'b0;
    pcSel_d   = PCSEL_BR;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (isBreak && (HALT_ON_BREAK != 0)) begin
          state_d = ST_HALT;
        end else if (isJump) begin
          state_d   = ST_PCUPD;
          pcSel_d   = PCSEL_J;
          exStart_d = needsExec;
        end else begin
          state_d   = ST_EXEC;
          exStart_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if ((waitCnt_q != '0) && ex_done) begin
          if (isJr) begin
            state_d = ST_PCUPD;
            pcSel_d = PCSEL_REG;
          end else if (brTaken) begin
            state_d = ST_PCUPD;
            pcSel_d = PCSEL_BR;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (waitCnt_q == WaitLast) begin
          state_d = ST_ERR;
        end
      end
      ST_PCUPD:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_RESET;
    endcase
  end

  // State register plus registered Moore outputs decoded from the state being
  // entered; reset clears everything immediately so no stray pc_ld/ir_ld.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET;
      opHeld_q  <= '0;
      fnHeld_q  <= '0;
      waitCnt_q <= '0;
      ex_start  <= 1'b0;
      pc_sel    <= PCSEL_BR;
      pc_ld     <= 1'b0;
      pc_inc    <= 1'b0;
      im_cs     <= 1'b0;
      im_rd     <= 1'b0;
      ir_ld     <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_start <= exStart_d;
      pc_sel   <= (state_d == ST_PCUPD) ? pcSel_d : PCSEL_BR;
      pc_ld    <= (state_d == ST_PCUPD);
      pc_inc   <= (state_d == ST_FETCH);
      im_cs    <= (state_d == ST_FETCH);
      im_rd    <= (state_d == ST_FETCH);
      ir_ld    <= (state_d == ST_FETCH);
      halted   <= (state_d == ST_HALT);
      err      <= err | (state_d == ST_ERR);
      if (state_q == ST_DECODE) begin
        opHeld_q <= opcode;
        fnHeld_q <= funct;
      end
      if ((state_q == ST_EXEC) && (state_d == ST_EXEC)) begin
        waitCnt_q <= waitCnt_q + 1'b1;
      end else if (state_d == ST_EXEC) begin
        waitCnt_q <= '0;
      end
    end
  end

  assign im_wr = 1'b0;
  assign state = state_q;

`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        pendRetire_q;
  logic        instrDone;

  assign instrDone = ((state_q == ST_EXEC) && (state_d != ST_EXEC) && (state_d != ST_ERR)) ||
                     (state_q == ST_PCUPD);

  // Completion is remembered and credited on the next FETCH->DECODE, so a
  // taken branch (EXEC then PCUPD) still counts only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q    <= '0;
      pendRetire_q <= 1'b0;
    end else if (instrDone) begin
      pendRetire_q <= 1'b1;
    end else if ((state_q == ST_FETCH) && (state_d == ST_DECODE)) begin
      if (pendRetire_q) begin
        retired_q <= retired_q + 32'd1;
      end
      pendRetire_q <= 1'b0;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. Each step drives inputs, pushes the
// expected output vector to a scoreboard, clocks once and pops/compares.
// A second instance with HALT_ON_BREAK=0 shares the stimulus.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_z = 1'b0;
  logic       ex_done = 1'b0;

  logic       ex_start, pc_ld, pc_inc, im_cs, im_rd, im_wr, ir_ld, halted, err;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic       ex_start2, pc_ld2, pc_inc2, im_cs2, im_rd2, im_wr2, ir_ld2, halted2, err2;
  logic [1:0] pc_sel2;
  logic [2:0] state2;
`ifdef FETCH_SEQ_RETIRE_CNT_EN
  logic [31:0] retired, retired2;
`endif

  fetch_sequencer #(.HALT_ON_BREAK(1), .EXEC_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_z(alu_z), .ex_done(ex_done), .ex_start(ex_start), .pc_sel(pc_sel),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .im_cs(im_cs), .im_rd(im_rd),
    .im_wr(im_wr), .ir_ld(ir_ld), .halted(halted), .err(err), .state(state)
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  fetch_sequencer #(.HALT_ON_BREAK(0), .EXEC_TIMEOUT(16)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_z(alu_z), .ex_done(ex_done), .ex_start(ex_start2), .pc_sel(pc_sel2),
    .pc_ld(pc_ld2), .pc_inc(pc_inc2), .im_cs(im_cs2), .im_rd(im_rd2),
    .im_wr(im_wr2), .ir_ld(ir_ld2), .halted(halted2), .err(err2), .state(state2)
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    , .retired(retired2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] vec;
    logic        chk2;
    logic [13:0] vec2;
    string       tag;
  } sbItem_t;

  sbItem_t scoreboard[$];
  int testsRun = 0;
  int testsFailed = 0;

  // Expected output vector: FETCH implies pc_inc/im_cs/im_rd/ir_ld, im_wr is 0.
  function automatic logic [13:0] ev(input logic [2:0] st, input logic exs,
                                     input logic [1:0] sel, input logic ld,
                                     input logic hlt, input logic er);
    logic f;
    f = (st == 3'd1);
    return {st, exs, sel, ld, f, f, f, 1'b0, f, hlt, er};
  endfunction

  // Pops the oldest expectation and compares it against both instances.
  task automatic checkOutput();
    sbItem_t     item;
    logic [13:0] obs, obs2;
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    item = scoreboard.pop_front();
    obs  = {state, ex_start, pc_sel, pc_ld, pc_inc, im_cs, im_rd, im_wr, ir_ld, halted, err};
    obs2 = {state2, ex_start2, pc_sel2, pc_ld2, pc_inc2, im_cs2, im_rd2, im_wr2, ir_ld2, halted2, err2};
    testsRun++;
    assert (obs === item.vec) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", item.tag, obs, item.vec);
    end
    if (item.chk2) begin
      testsRun++;
      assert (obs2 === item.vec2) else begin
        testsFailed++;
        $error("[TB] FAIL %s_nohalt observed=%h expected=%h", item.tag, obs2, item.vec2);
      end
    end
  endtask

  // Drives one cycle of inputs, records the expectation, clocks, then checks.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic done,
                               input logic [13:0] expVec, input string tag,
                               input logic chk2 = 1'b0,
                               input logic [13:0] expVec2 = '0);
    sbItem_t item;
    opcode  = op;
    funct   = fn;
    alu_z   = z;
    ex_done = done;
    item.vec  = expVec;
    item.chk2 = chk2;
    item.vec2 = expVec2;
    item.tag  = tag;
    scoreboard.push_back(item);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic expectNow(input logic [13:0] expVec, input string tag);
    sbItem_t item;
    item.vec  = expVec;
    item.chk2 = 1'b0;
    item.vec2 = '0;
    item.tag  = tag;
    scoreboard.push_back(item);
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [13:0] haltExp2 [3];

    repeat (2) @(posedge clk);
    #1;
    expectNow(ev(3'd0, 0, 2'b00, 0, 0, 0), "reset");
`ifdef FETCH_SEQ_RETIRE_CNT_EN
    testsRun++;
    assert (retired === 32'd0) else begin
      testsFailed++;
      $error("[TB] FAIL retired_reset observed=%0d expected=0", retired);
    end
`endif
    reset = 1'b0;

    // add: 0,1,2,3,3,1 with ex_done high throughout (ignored on start cycle)
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "add_fetch");
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "add_decode");
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), "add_exec1");
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), "add_exec2");
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "add_fetch2");

    // BEQ taken; IR changes to an add during EXEC and must be ignored
    applyStimulus(6'h04, 6'h00, 1, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "beq1_decode");
    applyStimulus(6'h04, 6'h00, 1, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), "beq1_exec1");
    applyStimulus(6'h00, 6'h20, 1, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), "beq1_exec2");
    applyStimulus(6'h00, 6'h20, 1, 1, ev(3'd4, 0, 2'b00, 1, 0, 0), "beq1_pcupd");
    applyStimulus(6'h00, 6'h20, 1, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "beq1_fetch");

    // BEQ not taken
    applyStimulus(6'h04, 6'h00, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "beq0_decode");
    applyStimulus(6'h04, 6'h00, 0, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), "beq0_exec1");
    applyStimulus(6'h04, 6'h00, 0, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), "beq0_exec2");
    applyStimulus(6'h04, 6'h00, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "beq0_fetch");

    // BNE taken (alu_z low)
    applyStimulus(6'h05, 6'h00, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "bne_decode");
    applyStimulus(6'h05, 6'h00, 0, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), "bne_exec1");
    applyStimulus(6'h05, 6'h00, 0, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), "bne_exec2");
    applyStimulus(6'h05, 6'h00, 0, 1, ev(3'd4, 0, 2'b00, 1, 0, 0), "bne_pcupd");
    applyStimulus(6'h05, 6'h00, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "bne_fetch");

    // J: no execute, pc_sel=01
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0), "j_decode");
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd4, 0, 2'b01, 1, 0, 0), "j_pcupd");
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd1, 0, 2'b00, 0, 0, 0), "j_fetch");

    // JAL: ex_start pulses alongside PCUPD
    applyStimulus(6'h03, 6'h00, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0), "jal_decode");
    applyStimulus(6'h03, 6'h00, 0, 0, ev(3'd4, 1, 2'b01, 1, 0, 0), "jal_pcupd");
    applyStimulus(6'h03, 6'h00, 0, 0, ev(3'd1, 0, 2'b00, 0, 0, 0), "jal_fetch");

    // JR: through EXEC, then pc_sel=10
    applyStimulus(6'h00, 6'h08, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "jr_decode");
    applyStimulus(6'h00, 6'h08, 0, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), "jr_exec1");
    applyStimulus(6'h00, 6'h08, 0, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), "jr_exec2");
    applyStimulus(6'h00, 6'h08, 0, 1, ev(3'd4, 0, 2'b10, 1, 0, 0), "jr_pcupd");
    applyStimulus(6'h00, 6'h08, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "jr_fetch");

    // Execute timeout: ERR exactly 16 cycles after EXEC entry, sticky
    applyStimulus(6'h00, 6'h20, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0), "to_decode");
    applyStimulus(6'h00, 6'h20, 0, 0, ev(3'd3, 1, 2'b00, 0, 0, 0), "to_exec1");
    for (int k = 2; k <= 16; k++) begin
      applyStimulus(6'h00, 6'h20, 0, 0, ev(3'd3, 0, 2'b00, 0, 0, 0), $sformatf("to_exec%0d", k));
    end
    applyStimulus(6'h00, 6'h20, 0, 0, ev(3'd6, 0, 2'b00, 0, 0, 1), "to_err");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd6, 0, 2'b00, 0, 0, 1), $sformatf("to_sticky%0d", k));
    end
    #2;
    reset = 1'b1;
    #1;
    expectNow(ev(3'd0, 0, 2'b00, 0, 0, 0), "to_reset_clears");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // BREAK: dut halts; no-halt instance treats it as an ordinary instruction
    applyStimulus(6'h00, 6'h0D, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "brk_fetch");
    applyStimulus(6'h00, 6'h0D, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "brk_decode",
                  1'b1, ev(3'd2, 0, 2'b00, 0, 0, 0));
    haltExp2[0] = ev(3'd3, 1, 2'b00, 0, 0, 0);
    haltExp2[1] = ev(3'd3, 0, 2'b00, 0, 0, 0);
    haltExp2[2] = ev(3'd1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (k < 3) begin
        applyStimulus(6'h00, 6'h0D, 0, 1, ev(3'd5, 0, 2'b00, 0, 1, 0),
                      $sformatf("brk_halt%0d", k), 1'b1, haltExp2[k]);
      end else begin
        applyStimulus(6'h02, 6'h00, 1, 1, ev(3'd5, 0, 2'b00, 0, 1, 0),
                      $sformatf("brk_halt%0d", k));
      end
    end

    // Reset asserted during PCUPD drops pc_ld immediately
    doReset();
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd1, 0, 2'b00, 0, 0, 0), "rp_fetch");
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd2, 0, 2'b00, 0, 0, 0), "rp_decode");
    applyStimulus(6'h02, 6'h00, 0, 0, ev(3'd4, 0, 2'b01, 1, 0, 0), "rp_pcupd");
    #2;
    reset = 1'b1;
    #1;
    expectNow(ev(3'd0, 0, 2'b00, 0, 0, 0), "rp_async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef FETCH_SEQ_RETIRE_CNT_EN
    // Five completed adds, credited on each following FETCH->DECODE
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), "rc_fetch");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), $sformatf("rc_decode%0d", n));
      applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd3, 1, 2'b00, 0, 0, 0), $sformatf("rc_exec1_%0d", n));
      applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd3, 0, 2'b00, 0, 0, 0), $sformatf("rc_exec2_%0d", n));
      applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd1, 0, 2'b00, 0, 0, 0), $sformatf("rc_fetch%0d", n));
    end
    applyStimulus(6'h00, 6'h20, 0, 1, ev(3'd2, 0, 2'b00, 0, 0, 0), "rc_decode_last");
    testsRun++;
    assert (retired === 32'd5) else begin
      testsFailed++;
      $error("[TB] FAIL retired_count observed=%0d expected=5", retired);
    end
    testsRun++;
    assert (retired2 === 32'd5) else begin
      testsFailed++;
      $error("[TB] FAIL retired_count_nohalt observed=%0d expected=5", retired2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
